mux8_rr_arbiter: RTL

- Round-robin arbiter and sequencer for the 8:1 2-bit channel multiplexer.
- Shares the single mux output path between 8 requesting bus channels and drives the mux `sel` input.
- Holds the selection for the full duration of a transaction, then rotates priority.
- Sits between the per-channel bus interfaces and the shared mux/downstream consumer.

---
 rtl/mux8_rr_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer that shares one 8:1 mux path among 8 request channels.
// Latency: grant 1 clock after the req sample in IDLE; at least 3 clocks per grant (IDLE->ACTIVE->RELEASE).
// Backpressure: a requester holds req until served; en low blocks new grants only, and a hold ends on done, req drop or timeout.
module mux8_rr_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       timeout_err,
  output logic [2:0] err_id
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Counter value on the last permitted ACTIVE cycle; the counter saturates at all-ones.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       grant_nxt;
  logic [2:0]       sel_nxt;
  logic             busy_nxt;
  logic             terr_nxt;
  logic [2:0]       err_id_nxt;

  logic             pick_vld;
  logic [2:0]       pick_idx;
  logic [2:0]       cand;

  // Rotating priority search: scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr;
    cand     = ptr;
    for (int i = 7; i >= 0; i--) begin
      cand = ptr + 3'(i);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and registered-output logic; timeout_err is a single-cycle pulse by default.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    cnt_nxt    = cnt;
    grant_nxt  = grant;
    sel_nxt    = sel;
    busy_nxt   = busy;
    terr_nxt   = 1'b0;
    err_id_nxt = err_id;
    case (state)
      IDLE: begin
        grant_nxt = 8'h00;
        busy_nxt  = 1'b0;
        if (en && pick_vld) begin
          state_nxt = ACTIVE;
          sel_nxt   = pick_idx;
          grant_nxt = 8'(1) << pick_idx;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      ACTIVE: begin
        if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
        if (done || !req[sel] || (cnt == CNT_LAST)) begin
          state_nxt = RELEASE;
          grant_nxt = 8'h00;
          busy_nxt  = 1'b0;
          ptr_nxt   = sel + 3'd1;
          // A done or requester abort in the same cycle takes precedence over the timeout.
          if (!done && req[sel]) begin
            terr_nxt   = 1'b1;
            err_id_nxt = sel;
          end
        end
      end
      RELEASE: begin
        state_nxt = IDLE;
        grant_nxt = 8'h00;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 8'h00;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset so grant drops immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= 3'd0;
      cnt         <= '0;
      grant       <= 8'h00;
      sel         <= 3'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      err_id      <= 3'd0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      grant       <= grant_nxt;
      sel         <= sel_nxt;
      busy        <= busy_nxt;
      timeout_err <= terr_nxt;
      err_id      <= err_id_nxt;
    end
  end

endmodule
